// File: rtl/pc_sequencer.sv
// pc_sequencer: round-robin per-thread program counter issue.
// One slot per cycle, one thread per slot, strictly rotating. Each slot applies
// the outcome (jump / IO_ready annul) of that thread's previous instruction,
// then issues the next PC one cycle later on registered outputs.
// Host control window on the ALU write port: run-enable mask and per-thread
// PC load.
// Optional: define PC_SEQUENCER_STALL_COUNT_EN to add a saturating 32-bit
// count of annulled re-issues, with a clear address just past the load window.

// Per-thread state: last issued PC, started flag, and one pending host load.
module pc_seq_lane #(
  parameter int PC_WIDTH = 10,
  parameter int START_PC = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                slot_sel,
  input  logic                load_wr,
  input  logic [PC_WIDTH-1:0] load_data,
  input  logic [PC_WIDTH-1:0] next_pc,
  input  logic                next_started,
  output logic [PC_WIDTH-1:0] pc,
  output logic                started,
  output logic                pend_vld,
  output logic [PC_WIDTH-1:0] pend_pc
);

  // The owning slot commits next-PC state and consumes any pending load
  // (a load landing in the slot itself was already folded into next_pc).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc       <= PC_WIDTH'(START_PC);
      started  <= 1'b0;
      pend_vld <= 1'b0;
      pend_pc  <= '0;
    end else if (slot_sel) begin
      pc       <= next_pc;
      started  <= next_started;
      pend_vld <= 1'b0;
    end else if (load_wr) begin
      pend_vld <= 1'b1;
      pend_pc  <= load_data;
    end
  end

endmodule

module pc_sequencer #(
  parameter int PC_WIDTH          = 10,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 0,
  parameter int START_PC          = 0,
  parameter logic [THREAD_COUNT-1:0] RESET_ENABLE_MASK = '1,
  parameter int D_OPERAND_WIDTH   = 10,
  parameter int WORD_WIDTH        = 36,
  parameter int CTRL_ADDR_BASE    = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         jump,
  input  logic [PC_WIDTH-1:0]          branch_destination,
  input  logic                         IO_ready,
  input  logic                         ALU_wren,
  input  logic [D_OPERAND_WIDTH-1:0]   ALU_write_addr,
  input  logic [WORD_WIDTH-1:0]        ALU_write_data,
  output logic [PC_WIDTH-1:0]          PC,
  output logic [THREAD_ADDR_WIDTH-1:0] PC_thread,
  output logic                         PC_valid,
  output logic [THREAD_COUNT-1:0]      enable_mask
`ifdef PC_SEQUENCER_STALL_COUNT_EN
  ,
  output logic [31:0]                  stall_count
`endif
);

  localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_T    = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
  localparam logic [D_OPERAND_WIDTH-1:0]   CTRL_BASE = D_OPERAND_WIDTH'(CTRL_ADDR_BASE);

  logic [THREAD_ADDR_WIDTH-1:0] t;

  logic [THREAD_COUNT-1:0][PC_WIDTH-1:0] lane_pc;
  logic [THREAD_COUNT-1:0][PC_WIDTH-1:0] lane_pend_pc;
  logic [THREAD_COUNT-1:0]               lane_started;
  logic [THREAD_COUNT-1:0]               lane_pend_vld;
  logic [THREAD_COUNT-1:0]               lane_load_wr;
  logic [THREAD_COUNT-1:0]               slot_sel;

  logic [D_OPERAND_WIDTH-1:0] ctrl_off;
  logic                       mask_wr;
  logic [PC_WIDTH-1:0]        load_data;

  logic [PC_WIDTH-1:0] cur_pc;
  logic                cur_started;
  logic                cur_en;
  logic                same_slot_wr;
  logic                load_hit;
  logic [PC_WIDTH-1:0] load_val;

  logic [PC_WIDTH-1:0] next_pc;
  logic                next_started;
  logic                next_valid;
  logic                stall_hit;

  // Only the low THREAD_COUNT / PC_WIDTH data bits carry meaning.
  logic data_unused;
  assign data_unused = ^ALU_write_data;

  // Control window decode, relative to the base (wraps harmlessly below it).
  assign ctrl_off  = ALU_write_addr - CTRL_BASE;
  assign mask_wr   = ALU_wren && (ctrl_off == '0);
  assign load_data = ALU_write_data[PC_WIDTH-1:0];

  genvar i;
  generate
    for (i = 0; i < THREAD_COUNT; i++) begin : g_lane
      assign slot_sel[i]     = (t == THREAD_ADDR_WIDTH'(i));
      assign lane_load_wr[i] = ALU_wren && (ctrl_off == D_OPERAND_WIDTH'(i + 1));

      pc_seq_lane #(
        .PC_WIDTH (PC_WIDTH),
        .START_PC (START_PC)
      ) u_lane (
        .clock        (clock),
        .reset_n      (reset_n),
        .slot_sel     (slot_sel[i]),
        .load_wr      (lane_load_wr[i]),
        .load_data    (load_data),
        .next_pc      (next_pc),
        .next_started (next_started),
        .pc           (lane_pc[i]),
        .started      (lane_started[i]),
        .pend_vld     (lane_pend_vld[i]),
        .pend_pc      (lane_pend_pc[i])
      );
    end
  endgenerate

  // Current slot's thread state; a load written in this very slot wins over
  // an older pending one.
  assign cur_pc       = lane_pc[t];
  assign cur_started  = lane_started[t];
  assign cur_en       = enable_mask[t];
  assign same_slot_wr = |(slot_sel & lane_load_wr);
  assign load_hit     = same_slot_wr | lane_pend_vld[t];
  assign load_val     = same_slot_wr ? load_data : lane_pend_pc[t];

  // Next-PC priority: host load, disabled, first issue, annul, jump, increment.
  always_comb begin
    next_pc      = cur_pc;
    next_started = cur_started;
    next_valid   = 1'b0;
    stall_hit    = 1'b0;
    if (load_hit) begin
      next_pc      = load_val;
      next_started = 1'b0;
    end else if (!cur_en) begin
      next_valid   = 1'b0;
    end else if (!cur_started) begin
      next_started = 1'b1;
      next_valid   = 1'b1;
    end else if (!IO_ready) begin
      next_valid   = 1'b1;
      stall_hit    = 1'b1;
    end else if (jump) begin
      next_pc      = branch_destination;
      next_valid   = 1'b1;
    end else begin
      next_pc      = cur_pc + PC_WIDTH'(1);
      next_valid   = 1'b1;
    end
  end

  // Slot rotation, registered issue outputs and the run-enable mask.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      t           <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
      PC          <= '0;
      PC_thread   <= '0;
      PC_valid    <= 1'b0;
      enable_mask <= RESET_ENABLE_MASK;
    end else begin
      t         <= (t == LAST_T) ? '0 : t + THREAD_ADDR_WIDTH'(1);
      PC        <= next_pc;
      PC_thread <= t;
      PC_valid  <= next_valid;
      if (mask_wr)
        enable_mask <= ALU_write_data[THREAD_COUNT-1:0];
    end
  end

`ifdef PC_SEQUENCER_STALL_COUNT_EN
  logic stall_clr;
  assign stall_clr = ALU_wren && (ctrl_off == D_OPERAND_WIDTH'(THREAD_COUNT + 1));

  // Saturating annul counter; a host clear takes precedence over a same-cycle hit.
  always_ff @(posedge clock) begin
    if (!reset_n)
      stall_count <= '0;
    else if (stall_clr)
      stall_count <= '0;
    else if (stall_hit && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end
`else
  logic stall_unused;
  assign stall_unused = stall_hit;
`endif

endmodule
